// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial arithmetic sequencers.
package serial_adder_ctrl_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full-adder cell built from gate-level logic only.
module structuralFullAdder (
   output logic sum,
   output logic carryout,
   input  logic a,
   input  logic b,
   input  logic carryin
);

   logic a_xor_b;

   assign a_xor_b  = a ^ b;
   assign sum      = a_xor_b ^ carryin;
   assign carryout = (a & b) | (a_xor_b & carryin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused LSB first, one bit per clock.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             last_bit;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic [CW-1:0]    count;
   logic             cell_sum;
   logic             cell_carry;

   structuralFullAdder u_fa (
      .sum      (cell_sum),
      .carryout (cell_carry),
      .a        (a_sh[0]),
      .b        (b_sh[0]),
      .carryin  (carry)
   );

   assign last_bit = (count == CW'(WIDTH - 1));

   // Next-state decode and start acceptance (IDLE and DONE are both ready states).
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_bit) state_next = DONE;
         end
         DONE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register, operand shifters, carry flop, bit counter and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         result <= '0;
         carry  <= 1'b0;
         count  <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
         end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= cell_carry;
            result <= {cell_sum, result[WIDTH-1:1]};
            count  <= count + CW'(1);
            // Final bit goes straight into the visible result so sum/cout
            // change only on the transition into DONE.
            if (last_bit) begin
               sum  <= {cell_sum, result[WIDTH-1:1]};
               cout <= cell_carry;
            end
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: cycle model plus directed literals.
module tb_serial_adder_ctrl;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: countdown of remaining cycles, result from plain addition.
   bit           m_running = 1'b0;
   int           m_left = 0;
   logic [W:0]   m_pend = '0;
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_sum = '0;
   logic         m_cout = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_running = 1'b0;
         m_left    = 0;
         m_busy    = 1'b0;
         m_done    = 1'b0;
         m_sum     = '0;
         m_cout    = 1'b0;
      end else if (!m_running && start) begin
         m_running = 1'b1;
         m_left    = W;
         m_pend    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         m_busy    = 1'b1;
         m_done    = 1'b0;
      end else if (m_running) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_running     = 1'b0;
            m_busy        = 1'b0;
            m_done        = 1'b1;
            {m_cout, m_sum} = m_pend;
         end
      end else begin
         m_done = 1'b0;
      end
   end

   // Cycle-by-cycle comparison against the model, away from the clock edge.
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("model_busy", {31'b0, busy}, {31'b0, m_busy});
         chk("model_done", {31'b0, done}, {31'b0, m_done});
         chk("model_sum", {24'b0, sum}, {24'b0, m_sum});
         chk("model_cout", {31'b0, cout}, {31'b0, m_cout});
      end
   end

   // One start pulse; checks latency, busy length and literal result.
   task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic [W-1:0] esum, input logic ecout,
                         input logic [W-1:0] held);
      int lat;
      int busyc;
      bit got;
      lat = 0; busyc = 0; got = 1'b0;
      @(negedge clk);
      a = ta; b = tb; cin = tc; start = 1'b1;
      for (int k = 1; k <= 20 && !got; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         end
         if (k == 4) chk({nm, "_held"}, {24'b0, sum}, {24'b0, held});
         if (busy) busyc++;
         if (done) begin
            got = 1'b1;
            lat = k;
         end
      end
      chk({nm, "_latency"}, lat, W + 1);
      chk({nm, "_busycycles"}, busyc, W);
      chk({nm, "_sum"}, {24'b0, sum}, {24'b0, esum});
      chk({nm, "_cout"}, {31'b0, cout}, {31'b0, ecout});
   endtask

   initial begin
      int donec;
      int t1;
      int t2;
      logic [W-1:0] s1;
      logic [W-1:0] s2;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic [W:0]   rs;

      repeat (2) @(negedge clk);
      cmp_on = 1'b1;
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_sum", {24'b0, sum}, 32'd0);
      chk("reset_cout", {31'b0, cout}, 32'd0);
      rst_n = 1'b1;

      run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
      run_op("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00);
      run_op("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 8'h00);
      run_op("7f_80", 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0, 8'h00);
      run_op("hold_ff", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 8'hFF);

      // start spammed during RUN with new operands: must be ignored
      @(negedge clk);
      a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
      donec = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k <= 8) begin
            start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         end else begin
            start = 1'b0;
         end
         if (done) begin
            donec++;
            chk("spam_sum", {24'b0, sum}, 32'h77);
            chk("spam_cout", {31'b0, cout}, 32'd0);
         end
      end
      chk("spam_donecount", donec, 1);

      // start held high: back-to-back operations
      @(negedge clk);
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      t1 = -1; t2 = -1; s1 = '0; s2 = '0;
      for (int k = 1; k <= 30 && t2 < 0; k++) begin
         @(negedge clk);
         if (k == 1) begin a = 8'h10; b = 8'h20; end
         if (k == 10) start = 1'b0;
         if (done) begin
            if (t1 < 0) begin t1 = k; s1 = sum; end
            else begin t2 = k; s2 = sum; end
         end
      end
      chk("b2b_first_time", t1, W + 1);
      chk("b2b_spacing", t2 - t1, W + 1);
      chk("b2b_sum1", {24'b0, s1}, 32'h02);
      chk("b2b_sum2", {24'b0, s2}, 32'h30);

      // reset mid-RUN at bit 4
      @(negedge clk);
      a = 8'hC3; b = 8'h3C; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_done", {31'b0, done}, 32'd0);
      chk("midrst_sum", {24'b0, sum}, 32'd0);
      chk("midrst_cout", {31'b0, cout}, 32'd0);
      donec = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done) donec++;
      end
      chk("midrst_nodone", donec, 0);
      run_op("after_rst", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 8'h00);

      // random directed operations with arithmetic expectations
      s1 = 8'h01;
      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         rs = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         run_op("rand_op", ra, rb, rc, rs[W-1:0], rs[W], s1);
         s1 = rs[W-1:0];
      end

      // free-running random traffic checked only by the model
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         rst_n = ($urandom_range(0, 99) != 0);
      end
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0;
      repeat (12) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
